regfile_mp_sb: RTL and testbench

//  Parametrised multi-port register file with a scoreboard, the next generation of the core GPR file.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_scoreboard.sv | 70 +++++++
 rtl/regfile_mp_sb.sv | 84 ++++++++
 tb/tb_regfile_mp_sb.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file and its scoreboard.
package regfile_pkg;

    localparam int REGFILE_DATA_W = 32;
    localparam int REGFILE_DEPTH  = 32;
    localparam int REGFILE_AW     = $clog2(REGFILE_DEPTH);

    typedef logic [REGFILE_AW-1:0]     reg_addr_t;
    typedef logic [REGFILE_DATA_W-1:0] reg_data_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: reserve at issue, release on writeback, clear on flush.
// With REGFILE_BYPASS_EN, rd_busy reports the post-write busy state of a register being written this cycle.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH  = REGFILE_DEPTH,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_busy,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_addr,
    output logic                 rsv_ready,
    input  logic                 flush
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Reserve handshake: a reservation is taken only on a cycle where rsv_en && rsv_ready;
    // with rsv_en && !rsv_ready nothing changes and the issuer must hold and retry.
    assign rsv_ready = ~busy_q[rsv_addr];

    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] != AW'(ZERO_REG))) begin
                busy_d[wr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        // A reserve is applied after the release so the new producer wins on a same-reg collision.
        if (flush) begin
            busy_d = '0;
        end else if (rsv_en && rsv_ready && (rsv_addr != AW'(ZERO_REG))) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] ra;
        logic          b;
        assign ra = rd_addr[p*AW +: AW];
        always_comb begin
            b = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] == ra) && (ra != AW'(ZERO_REG))) begin
                    b = 1'b0;
                end
            end
`endif
        end
        assign rd_busy[p] = b;
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port GPR file with register 0 hardwired to zero and an in-flight producer scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int DEPTH  = REGFILE_DEPTH,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_RD*$clog2(DEPTH)-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0]      rd_data,
    output logic [NUM_RD-1:0]             rd_busy,
    input  logic [NUM_WR-1:0]             wr_en,
    input  logic [NUM_WR*$clog2(DEPTH)-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]      wr_data,
    input  logic                          rsv_en,
    input  logic [$clog2(DEPTH)-1:0]      rsv_addr,
    output logic                          rsv_ready,
    input  logic                          flush
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Ports are applied in index order so the highest-index port wins a same-address collision.
    always_comb begin
        mem_d = mem_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] != AW'(ZERO_REG))) begin
                mem_d[wr_addr[w*AW +: AW]] = wr_data[w*DATA_W +: DATA_W];
            end
        end
        mem_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]     ra;
        logic [DATA_W-1:0] rv;
        assign ra = rd_addr[p*AW +: AW];
        always_comb begin
            rv = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] == ra) && (ra != AW'(ZERO_REG))) begin
                    rv = wr_data[w*DATA_W +: DATA_W];
                end
            end
`endif
        end
        assign rd_data[p*DATA_W +: DATA_W] = rv;
    end

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR),
        .AW     (AW)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .flush     (flush)
    );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: reset, writes, priority, scoreboard, flush, bypass, mid-run reset.
module tb_regfile_mp_sb;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        rsv_ready;
    logic        flush;

    int n_total;
    int n_pass;

    regfile_mp_sb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .flush     (flush)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic idle();
        wr_en  = '0;
        rsv_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_rd(input int p, input logic [4:0] a);
        rd_addr[p*5 +: 5] = a;
    endtask

    task automatic set_wr(input int w, input logic [4:0] a, input logic [31:0] d);
        wr_en[w]            = 1'b1;
        wr_addr[w*5 +: 5]   = a;
        wr_data[w*32 +: 32] = d;
    endtask

    task automatic set_rsv(input logic [4:0] a);
        rsv_en   = 1'b1;
        rsv_addr = a;
    endtask

    function automatic logic [31:0] rdat(input int p);
        return rd_data[p*32 +: 32];
    endfunction

    initial begin
        n_total  = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_addr = '0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;

        // 1. reset state on every register and port
        for (int r = 0; r < 32; r++) begin
            set_rd(0, 5'(r));
            set_rd(1, 5'(31 - r));
            rsv_addr = 5'(r);
            settle();
            check($sformatf("rst_data0_r%0d", r), rdat(0), 32'h0);
            check($sformatf("rst_data1_r%0d", 31 - r), rdat(1), 32'h0);
            check($sformatf("rst_busy_r%0d", r), {30'b0, rd_busy}, 32'h0);
            check($sformatf("rst_ready_r%0d", r), {31'b0, rsv_ready}, 32'h1);
        end

        // 2. basic write and write to r0
        set_wr(0, 5'd5, 32'hDEADBEEF);
        set_wr(1, 5'd0, 32'h1234);
        tick();
        idle();
        set_rd(0, 5'd5);
        set_rd(1, 5'd0);
        settle();
        check("wr_r5", rdat(0), 32'hDEADBEEF);
        check("wr_r0_dropped", rdat(1), 32'h0);

        // 3. same-address priority, and two distinct addresses together
        set_wr(0, 5'd7, 32'h11);
        set_wr(1, 5'd7, 32'h22);
        tick();
        set_wr(0, 5'd10, 32'hAA);
        set_wr(1, 5'd11, 32'hBB);
        tick();
        idle();
        set_rd(0, 5'd7);
        set_rd(1, 5'd7);
        settle();
        check("prio_r7_p0", rdat(0), 32'h22);
        check("prio_r7_p1", rdat(1), 32'h22);
        set_rd(0, 5'd10);
        set_rd(1, 5'd11);
        settle();
        check("dual_r10", rdat(0), 32'hAA);
        check("dual_r11", rdat(1), 32'hBB);

        // 4. reserve, blocked re-reserve, writeback release
        set_rsv(5'd3);
        set_rd(0, 5'd3);
        settle();
        check("rsv3_ready_before", {31'b0, rsv_ready}, 32'h1);
        tick();
        check("rsv3_busy", {31'b0, rd_busy[0]}, 32'h1);
        check("rsv3_ready_after", {31'b0, rsv_ready}, 32'h0);
        tick();
        idle();
        settle();
        check("rsv3_again_busy", {31'b0, rd_busy[0]}, 32'h1);
        check("rsv3_again_data", rdat(0), 32'h0);
        set_wr(0, 5'd3, 32'h5);
        tick();
        idle();
        rsv_addr = 5'd3;
        settle();
        check("wb3_busy", {31'b0, rd_busy[0]}, 32'h0);
        check("wb3_data", rdat(0), 32'h5);
        check("wb3_ready", {31'b0, rsv_ready}, 32'h1);

        // 5. reserve+write same reg, then flush beats reserve, reserve of r0
        set_rsv(5'd9);
        set_wr(1, 5'd9, 32'hA);
        tick();
        idle();
        set_rd(0, 5'd9);
        set_rd(1, 5'd4);
        settle();
        check("rsvwr9_busy", {31'b0, rd_busy[0]}, 32'h1);
        check("rsvwr9_data", rdat(0), 32'hA);
        flush = 1'b1;
        set_rsv(5'd4);
        tick();
        idle();
        settle();
        check("flush_busy_r9_r4", {30'b0, rd_busy}, 32'h0);
        set_rsv(5'd0);
        settle();
        check("rsv0_ready", {31'b0, rsv_ready}, 32'h1);
        tick();
        idle();
        set_rd(0, 5'd0);
        settle();
        check("rsv0_busy", {31'b0, rd_busy[0]}, 32'h0);

        // 6. read during write
        set_wr(0, 5'd6, 32'h33);
        tick();
        idle();
        set_rsv(5'd6);
        tick();
        idle();
        set_wr(0, 5'd6, 32'h77);
        set_rd(0, 5'd6);
        set_rd(1, 5'd8);
        set_wr(1, 5'd8, 32'h2);
        settle();
`ifdef REGFILE_BYPASS_EN
        check("byp_r6_data", rdat(0), 32'h77);
        check("byp_r6_busy", {31'b0, rd_busy[0]}, 32'h0);
        check("byp_r8_data", rdat(1), 32'h2);
`else
        check("byp_r6_data", rdat(0), 32'h33);
        check("byp_r6_busy", {31'b0, rd_busy[0]}, 32'h1);
        check("byp_r8_data", rdat(1), 32'h0);
`endif
        tick();
        idle();
        settle();
        check("post_r6_data", rdat(0), 32'h77);
        check("post_r6_busy", {31'b0, rd_busy[0]}, 32'h0);
        check("post_r8_data", rdat(1), 32'h2);

        // 7. reset while writing and reserving
        set_rsv(5'd12);
        tick();
        idle();
        rst_n = 1'b0;
        set_wr(0, 5'd5, 32'hCAFE);
        set_wr(1, 5'd13, 32'hBEEF);
        set_rsv(5'd14);
        flush = 1'b1;
        tick();
        rst_n = 1'b1;
        idle();
        set_rd(0, 5'd5);
        set_rd(1, 5'd13);
        settle();
        check("mrst_r5", rdat(0), 32'h0);
        check("mrst_r13", rdat(1), 32'h0);
        set_rd(0, 5'd12);
        set_rd(1, 5'd14);
        rsv_addr = 5'd12;
        settle();
        check("mrst_busy", {30'b0, rd_busy}, 32'h0);
        check("mrst_ready12", {31'b0, rsv_ready}, 32'h1);
        set_rd(0, 5'd7);
        set_rd(1, 5'd6);
        settle();
        check("mrst_r7", rdat(0), 32'h0);
        check("mrst_r6", rdat(1), 32'h0);

        // Final report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
